// File: rtl/cipher_byte_serializer_pkg.sv
// Shared definitions for the ciphertext block-to-byte serializer.
`timescale 1ns/1ps
package cipher_byte_serializer_pkg;

  localparam int DEF_DATA_WIDTH = 256;
  localparam int DEF_BYTE_WIDTH = 8;
  localparam int DEF_FIFO_DEPTH = 4;
  localparam int DEF_NBYTES     = DEF_DATA_WIDTH / DEF_BYTE_WIDTH;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

endpackage

// File: rtl/cipher_byte_serializer_if.sv
// Block input and byte-stream output of the serializer.
`timescale 1ns/1ps
interface cipher_byte_serializer_if
  import cipher_byte_serializer_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int BYTE_WIDTH = DEF_BYTE_WIDTH
);

  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  out_tvalid;
  logic                  out_tready;
  logic [BYTE_WIDTH-1:0] out_tdata;
  logic                  out_tlast;

  modport master (
    output in_valid, in_data, out_tready,
    input  out_tvalid, out_tdata, out_tlast
  );

  modport slave (
    input  in_valid, in_data, out_tready,
    output out_tvalid, out_tdata, out_tlast
  );

endinterface

// File: rtl/cipher_byte_serializer_block_fifo.sv
// Synchronous block FIFO; a push while full is accepted only when a pop frees the slot.
`timescale 1ns/1ps
module block_fifo #(
  parameter int WIDTH = 256,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic [WIDTH-1:0]             head
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_pop;
  logic             do_push;

  assign empty   = (level == '0);
  assign full    = (level == LW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_push && !do_pop)      level <= level + LW'(1);
      else if (do_pop && !do_push) level <= level - LW'(1);
    end
  end

  // Storage needs no reset: the pointers and level define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/cipher_byte_serializer.sv
// Buffers ciphertext blocks and streams each one out MSB byte first.
`timescale 1ns/1ps
module cipher_byte_serializer
  import cipher_byte_serializer_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int BYTE_WIDTH = DEF_BYTE_WIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                              clk,
  input  logic                              reset_n,
  cipher_byte_serializer_if.slave           bus,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level,
  output logic                              overflow
);

  localparam int NBYTES = DATA_WIDTH / BYTE_WIDTH;
  localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  state_t                state;
  state_t                state_next;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [IDX_W-1:0]      idx;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_head;
  logic                  pop;
  logic                  advance;
  logic                  handshake;

  block_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (bus.in_valid),
    .push_data (bus.in_data),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level),
    .head      (fifo_head)
  );

  assign handshake = (state == SEND) && bus.out_tready;

  // Empty is registered, so a block written while idle is popped one edge later.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    advance    = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          state_next = SEND;
        end
      end
      SEND: begin
        if (handshake) begin
          if (idx != LAST_IDX) begin
            advance = 1'b1;
          end else if (!fifo_empty) begin
            pop = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      shift_q  <= '0;
      idx      <= '0;
      overflow <= 1'b0;
    end else begin
      state <= state_next;
      if (pop) begin
        shift_q <= fifo_head;
        idx     <= '0;
      end else if (advance) begin
        shift_q <= {shift_q[DATA_WIDTH-BYTE_WIDTH-1:0], {BYTE_WIDTH{1'b0}}};
        idx     <= idx + IDX_W'(1);
      end
      if (bus.in_valid && fifo_full && !pop) overflow <= 1'b1;
    end
  end

  assign bus.out_tvalid = (state == SEND);
  assign bus.out_tdata  = (state == SEND) ? shift_q[DATA_WIDTH-1 -: BYTE_WIDTH] : '0;
  assign bus.out_tlast  = (state == SEND) && (idx == LAST_IDX);

endmodule

// File: tb/tb_cipher_byte_serializer.sv
// Directed table, corner-case sequences and random traffic against a queue model.
`timescale 1ns/1ps
module tb_cipher_byte_serializer;
  import cipher_byte_serializer_pkg::*;

  localparam int DW    = 256;
  localparam int BW    = 8;
  localparam int DEPTH = 4;
  localparam int NB    = DW / BW;
  localparam int LW    = $clog2(DEPTH + 1);

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [LW-1:0] fifo_level;
  logic overflow;

  always #5 clk = ~clk;

  cipher_byte_serializer_if #(.DATA_WIDTH(DW), .BYTE_WIDTH(BW)) bus ();

  cipher_byte_serializer #(
    .DATA_WIDTH (DW),
    .BYTE_WIDTH (BW),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .bus        (bus.slave),
    .fifo_level (fifo_level),
    .overflow   (overflow)
  );

  int checks = 0;
  int errors = 0;

  logic [BW-1:0] cur_q[$];
  logic [DW-1:0] blk_q[$];
  logic          m_ovf = 1'b0;

  typedef struct {
    logic          v;
    logic          r;
    logic          exp_valid;
    logic [BW-1:0] exp_data;
    logic          exp_last;
    int            exp_level;
  } vec_t;

  vec_t vecs[35];

  function automatic logic [DW-1:0] ramp_block();
    logic [DW-1:0] b;
    for (int i = 0; i < NB; i++) b[DW-1-i*BW -: BW] = BW'(i);
    return b;
  endfunction

  function automatic logic [DW-1:0] rand_block();
    logic [DW-1:0] b;
    for (int i = 0; i < DW/32; i++) b[i*32 +: 32] = $urandom;
    return b;
  endfunction

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a queue of buffered blocks plus the bytes still owed from the active one.
  task automatic model_step(input logic v, input logic [DW-1:0] d, input logic r);
    logic          hs;
    logic          popping;
    logic [DW-1:0] h;
    hs      = (cur_q.size() > 0) && r;
    popping = (blk_q.size() > 0) && ((cur_q.size() == 0) || (hs && cur_q.size() == 1));
    if (hs) void'(cur_q.pop_front());
    if (popping) begin
      h = blk_q.pop_front();
      for (int i = 0; i < NB; i++) cur_q.push_back(h[DW-1-i*BW -: BW]);
    end
    if (v) begin
      if (blk_q.size() < DEPTH) blk_q.push_back(d);
      else m_ovf = 1'b1;
    end
  endtask

  task automatic model_clear();
    cur_q.delete();
    blk_q.delete();
    m_ovf = 1'b0;
  endtask

  task automatic checkOutput();
    check_val("tvalid", 32'(bus.out_tvalid), 32'(cur_q.size() > 0));
    if (cur_q.size() > 0) begin
      check_val("tdata", 32'(bus.out_tdata), 32'(cur_q[0]));
      check_val("tlast", 32'(bus.out_tlast), 32'(cur_q.size() == 1));
    end
    check_val("level", 32'(fifo_level), 32'(blk_q.size()));
    check_val("overflow", 32'(overflow), 32'(m_ovf));
  endtask

  // Drive inputs at a falling edge, let one rising edge pass, then compare.
  task automatic applyStimulus(input logic v, input logic [DW-1:0] d, input logic r);
    bus.in_valid   = v;
    bus.in_data    = d;
    bus.out_tready = r;
    @(posedge clk);
    model_step(v, d, r);
    @(negedge clk);
    checkOutput();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n        = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    bus.out_tready = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    logic [DW-1:0] blks[6];
    logic [DW-1:0] ramp;
    int            hs_cnt;
    int            k;
    logic          r;

    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    bus.out_tready = 1'b0;
    ramp = ramp_block();

    vecs[0] = '{v: 1'b1, r: 1'b1, exp_valid: 1'b0, exp_data: '0, exp_last: 1'b0, exp_level: 1};
    for (int i = 0; i < NB; i++) begin
      vecs[1+i].v         = 1'b0;
      vecs[1+i].r         = 1'b1;
      vecs[1+i].exp_valid = 1'b1;
      vecs[1+i].exp_data  = BW'(i);
      vecs[1+i].exp_last  = (i == NB - 1);
      vecs[1+i].exp_level = 0;
    end
    for (int i = NB + 1; i < 35; i++)
      vecs[i] = '{v: 1'b0, r: 1'b1, exp_valid: 1'b0, exp_data: '0, exp_last: 1'b0, exp_level: 0};

    // Reset state
    do_reset();
    check_val("rst_tvalid", 32'(bus.out_tvalid), 32'd0);
    check_val("rst_tdata", 32'(bus.out_tdata), 32'd0);
    check_val("rst_tlast", 32'(bus.out_tlast), 32'd0);
    check_val("rst_level", 32'(fifo_level), 32'd0);
    check_val("rst_overflow", 32'(overflow), 32'd0);

    // Single ramp block, ready held high
    for (int i = 0; i < 35; i++) begin
      applyStimulus(vecs[i].v, ramp, vecs[i].r);
      check_val("tbl_tvalid", 32'(bus.out_tvalid), 32'(vecs[i].exp_valid));
      if (vecs[i].exp_valid) begin
        check_val("tbl_tdata", 32'(bus.out_tdata), 32'(vecs[i].exp_data));
        check_val("tbl_tlast", 32'(bus.out_tlast), 32'(vecs[i].exp_last));
      end
      check_val("tbl_level", 32'(fifo_level), 32'(vecs[i].exp_level));
    end

    // Backpressure with ready pattern 1,0,0,1,0,0,...
    do_reset();
    applyStimulus(1'b1, ramp, 1'b0);
    hs_cnt = 0;
    k = 0;
    while (hs_cnt < NB && k < 200) begin
      r = (k % 3 == 0);
      if (bus.out_tvalid) begin
        check_val("bp_tdata", 32'(bus.out_tdata), 32'(hs_cnt));
        check_val("bp_tlast", 32'(bus.out_tlast), 32'(hs_cnt == NB - 1));
        if (r) hs_cnt++;
      end
      applyStimulus(1'b0, '0, r);
      k++;
    end
    check_val("bp_handshakes", 32'(hs_cnt), 32'(NB));
    repeat (3) applyStimulus(1'b0, '0, 1'b1);
    check_val("bp_idle", 32'(bus.out_tvalid), 32'd0);

    // Burst of six blocks with ready low: one loaded, four queued, one dropped
    do_reset();
    for (int i = 0; i < 6; i++) blks[i] = rand_block();
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, blks[i], 1'b0);
    check_val("burst_level", 32'(fifo_level), 32'd4);
    check_val("burst_overflow", 32'(overflow), 32'd1);
    hs_cnt = 0;
    for (int c = 0; c < 5 * NB + 4; c++) begin
      if (bus.out_tvalid) begin
        if (hs_cnt < 5 * NB)
          check_val("burst_byte", 32'(bus.out_tdata),
                    32'(blks[hs_cnt / NB][DW-1-(hs_cnt % NB)*BW -: BW]));
        hs_cnt++;
      end
      applyStimulus(1'b0, '0, 1'b1);
    end
    check_val("burst_bytes", 32'(hs_cnt), 32'(5 * NB));
    check_val("burst_overflow_sticky", 32'(overflow), 32'd1);

    // Full FIFO with a push landing on the last-byte handshake
    do_reset();
    for (int i = 0; i < 6; i++) blks[i] = rand_block();
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, blks[i], 1'b0);
    for (int i = 0; i < NB - 1; i++) applyStimulus(1'b0, '0, 1'b1);
    check_val("full_pre_last", 32'(bus.out_tlast), 32'd1);
    applyStimulus(1'b1, blks[5], 1'b1);
    check_val("full_level", 32'(fifo_level), 32'd4);
    check_val("full_overflow", 32'(overflow), 32'd0);
    check_val("full_no_bubble", 32'(bus.out_tvalid), 32'd1);
    check_val("full_next_byte", 32'(bus.out_tdata), 32'(blks[1][DW-1 -: BW]));

    // Asynchronous reset after ten bytes with two blocks queued
    do_reset();
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, rand_block(), 1'b0);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, '0, 1'b1);
    check_val("pre_rst_level", 32'(fifo_level), 32'd2);
    #2 reset_n = 1'b0;
    #1;
    check_val("async_tvalid", 32'(bus.out_tvalid), 32'd0);
    check_val("async_tlast", 32'(bus.out_tlast), 32'd0);
    check_val("async_tdata", 32'(bus.out_tdata), 32'd0);
    check_val("async_level", 32'(fifo_level), 32'd0);
    check_val("async_overflow", 32'(overflow), 32'd0);
    model_clear();
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 40; i++) applyStimulus(1'b0, '0, 1'b1);
    applyStimulus(1'b1, ramp, 1'b1);
    applyStimulus(1'b0, '0, 1'b1);
    check_val("post_rst_first", 32'(bus.out_tdata), 32'd0);
    for (int i = 0; i < NB + 2; i++) applyStimulus(1'b0, '0, 1'b1);

    // Random traffic against the model
    do_reset();
    for (int c = 0; c < 3000; c++)
      applyStimulus(($urandom_range(0, 19) == 0), rand_block(), ($urandom_range(0, 3) != 0));
    for (int c = 0; c < 6 * NB; c++) applyStimulus(1'b0, '0, 1'b1);
    check_val("drain_tvalid", 32'(bus.out_tvalid), 32'd0);
    check_val("drain_level", 32'(fifo_level), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cipher_byte_serializer.md
Name: cipher_byte_serializer

Overview:
- Sits directly downstream of the Feistel encryption pipeline. It consumes the 256-bit ciphertext blocks, which arrive as single-cycle valid pulses with no backpressure.
- Buffers the blocks in a small FIFO and serializes each one, MSB byte first, onto an 8-bit valid/ready byte stream toward the image writer / output DMA.
- Absorbs the burstiness of the encryption pipeline: consecutive blocks may arrive on consecutive cycles. Any overrun is flagged, never silently hidden.

Parameters:
- DATA_WIDTH, 256, ciphertext block width; must be a multiple of BYTE_WIDTH.
- BYTE_WIDTH, 8, output symbol width.
- FIFO_DEPTH, 4, number of buffered blocks; power of two, >= 2.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  one-cycle pulse; in_data is a valid ciphertext block.
- in_data  in  DATA_WIDTH  ciphertext block.
- out_tvalid  out  1  out_tdata is valid.
- out_tready  in  1  consumer accepts the byte.
- out_tdata  out  BYTE_WIDTH  current byte.
- out_tlast  out  1  current byte is the last byte of its block.
- fifo_level  out  $clog2(FIFO_DEPTH+1)  number of blocks held in the FIFO (excludes the block being serialized).
- overflow  out  1  sticky; a block was dropped.

Behaviour:
- Reset (asynchronous, any time, including mid-block):
  - Outputs: out_tvalid=0, out_tdata=0, out_tlast=0, fifo_level=0, overflow=0.
  - FIFO pointers and byte index cleared; FSM returns to IDLE.
  - A block partially serialized when reset hits is lost; nothing resumes after reset.
- Constant NBYTES = DATA_WIDTH/BYTE_WIDTH (32 at defaults).
- Byte order: byte index 0 = in_data[DATA_WIDTH-1 -: BYTE_WIDTH], then descending.
- Write side: in_valid sampled on a clk edge.
  - If the FIFO is not full, the block is pushed.
  - If the FIFO is full and no pop occurs in the same cycle, the block is dropped, overflow is set, and FIFO contents are unchanged.
  - Full with a simultaneous pop: the push is accepted and the level is unchanged.
- FSM: two states, IDLE and SEND; shift register holds the active block; byte index is idx, 0..NBYTES-1.
  - IDLE: when the FIFO is non-empty, pop its head into the shift register, set idx=0, and go to SEND. out_tvalid rises the cycle after the pop edge.
  - SEND: out_tvalid=1, out_tdata=byte[idx], out_tlast=(idx==NBYTES-1).
  - SEND, handshake (out_tvalid && out_tready) with idx<NBYTES-1: idx increments.
  - SEND, handshake on the last byte, FIFO non-empty: pop and load the next block in the same edge, idx=0, stay in SEND. There is no bubble between blocks.
  - SEND, handshake on the last byte, FIFO empty: go to IDLE; out_tvalid=0 the next cycle.
- Output stability: while out_tvalid=1 and out_tready=0, out_tdata and out_tlast hold stable. out_tvalid never drops without a handshake.
- Latency: in_valid at edge k with FIFO empty and FSM IDLE -> push at edge k, pop at edge k+1, first byte valid after edge k+1.
- Throughput: 1 byte/cycle sustained. An input rate above 1 block per NBYTES cycles eventually overflows.
- Empty-FIFO write while in IDLE: the push and the pop must not occur in the same edge. The pop happens on the following edge, so there is no FIFO bypass.
- fifo_level is registered and updated on the same edge as the push/pop. Push and pop in the same cycle leave it unchanged.
- overflow is cleared only by reset.

Decomposition:
- Shared package: DATA_WIDTH/BYTE_WIDTH defaults, NBYTES, and the FSM state encoding (IDLE=0, SEND=1).
- Sub-module block_fifo, a synchronous FIFO:
  - Parameters: width DATA_WIDTH, depth FIFO_DEPTH.
  - Ports: push, pop, full, empty, level, head data.
  - Same clk and reset_n.
  - Pop on empty and push on full without pop are ignored.
- Top-level scope: FSM, shift/idx logic, overflow flag.

Test Plan:
- Single block, in_data bytes 0x00,0x01,...,0x1F (MSB first), out_tready=1 constantly:
  - out_tvalid high for exactly 32 consecutive cycles, starting 2 edges after the in_valid edge.
  - Bytes arrive as 0x00..0x1F in order, with out_tlast only on 0x1F.
  - fifo_level goes 1 then 0.
- Backpressure: same block, out_tready toggling 1,0,0,1,...:
  - Each byte is held stable while ready=0.
  - 32 handshakes total with no duplicates or skips.
  - out_tlast is stable across stalls.
- Burst of 6 blocks (A..F) on consecutive cycles, out_tready=0:
  - A is loaded into the shift register; B..E fill the FIFO (level=4).
  - F is dropped and overflow=1.
  - After ready=1, the stream is A,B,C,D,E (160 bytes, no gaps); overflow stays 1.
- Full FIFO, with in_valid on the same edge as the last-byte handshake of the active block:
  - The new block is accepted and fifo_level stays 4.
  - overflow stays 0.
  - The next block starts the following cycle with no bubble.
- Reset asserted after 10 bytes of a block with 2 blocks queued:
  - Outputs go immediately to their reset values (out_tvalid=0, fifo_level=0, overflow=0).
  - After release, no bytes appear until a new in_valid.
  - A new block is then serialized from byte 0.
